tcp_checksum_inserter: RTL and testbench
========================================

# tcp_checksum_inserter

Store-and-forward stage directly downstream of the TCP segment encoder. It captures the encoder's 32-bit word stream (header, options, payload), waits for the encoder's end-of-segment flag, and then inserts the final checksum into the header checksum field. It then replays the complete segment on a valid/ready output stream toward the IP-layer encapsulator. It exists because the checksum is only known after the last payload word has left the encoder.

## Interface
Parameters:
- ADDR_W, 9: buffer address width; capacity DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_data  in  32  encoder word (pkg_data).
- in_wr_en  in  1  in_data valid this cycle.
- in_fin  in  1  encoder end-of-segment level (stays high until the encoder is reset).
- in_checksum  in  16  final checksum; valid whenever in_fin is high.
- in_len  in  16  segment length in bytes (header + options + payload); valid whenever in_fin is high.
- start_ok  out  1  high when the buffer is empty and collecting; upstream must not start a segment otherwise.
- out_data  out  32  segment word, big-endian (byte 0 in [31:24]).
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the word when high with out_valid.
- out_last  out  1  marks the final word of the segment.
- out_keep  out  4  byte enables, [3] = byte 0; 4'b1111 except on the last word.
- out_len  out  16  latched in_len; stable while out_valid is high.
- overflow  out  1  one-cycle pulse: segment discarded because it exceeded DEPTH words.
- len_mismatch  out  1  sticky status: word count ≠ ceil(in_len/4); cleared at the next segment's first word.

## Operation
- States: COLLECT (reset state), SEND.
- fin edge = in_fin high while the registered previous in_fin is low. The previous-fin register resets to 0. A level held high after a segment never re-triggers.
- COLLECT:
  - Each in_wr_en writes in_data to mem[wr_cnt], then wr_cnt += 1.
  - Word index 4 is additionally captured into a word4 register.
  - Writes at wr_cnt ≥ DEPTH are dropped and set an internal ovf flag.
  - A word written in the same cycle as the fin edge is included.
- On fin edge in COLLECT:
  - Latch in_checksum, in_len and the final word count n (including the same-cycle write).
  - If ovf is set: pulse overflow, clear wr_cnt and ovf, stay in COLLECT.
  - Else if n == 0: discard, stay in COLLECT.
  - Else: set len_mismatch = (n ≠ (in_len+3)>>2), go to SEND.
- SEND:
  - Output words 0..n-1 in order, one per out_valid&out_ready handshake.
  - Word index 4 is replaced by {latched checksum, word4[15:0]}. Segments with n ≤ 4 are sent unmodified.
  - out_last is high on word n-1.
  - out_keep on the last word follows in_len[1:0]: 0→1111, 1→1000, 2→1100, 3→1110.
  - After the last handshake: wr_cnt ← 0, go to COLLECT.
  - in_wr_en and fin edges during SEND are ignored.
- start_ok = (state == COLLECT) && (wr_cnt == 0) && !ovf.
- Reset at any point: state COLLECT, wr_cnt 0, buffer contents abandoned, all outputs 0. The previous-fin register is 0, so an in_fin still high after reset triggers a fin edge.

## Timing
- Reset values: out_data 0, out_valid 0, out_last 0, out_keep 0, out_len 0, overflow 0, len_mismatch 0. start_ok is 1 in the first cycle after reset.
- Memory read is synchronous; out_data and out_valid are registered.
- Fin edge sampled at edge T: state becomes SEND at T+1, and out_valid with word 0 is visible after edge T+2.
- Throughput is one word per cycle while out_ready is high. There are no bubbles between words of a segment.
- Output hold: while out_valid && !out_ready, out_data, out_last and out_keep hold stable.
- The last handshake at edge E drops out_valid after E, and start_ok rises after E.
- The overflow pulse is high for exactly the cycle after the fin edge.

## Test plan
- Header-only segment: 5 words 0x1234ABCD, 0x00000001, 0x00000002, 0x50120400, 0x00000007; checksum 0xBEEF; in_len 20; out_ready=1. Required: 5 consecutive words, word 4 = 0xBEEF0007, out_last on word 4, out_keep 1111, len_mismatch 0.
- Payload segment: in_len 22, 6 words. Required: out_keep 1100 and out_last on word 5; word 4 patched; start_ok rises the cycle after word 5's handshake.
- Backpressure: out_ready toggling 1,0,0,1,… over a 7-word segment. Required: no duplicated or skipped words, and outputs stable while stalled.
- Overflow with ADDR_W=3: 10 words, then fin. Required: overflow pulses once, out_valid never rises; a following 5-word segment is output correctly.
- Mismatch and fin level: 6 words with in_len 20. Required: len_mismatch = 1 and all 6 words sent. in_fin then held high. Required: no second transmission.
- Reset asserted on the third word of SEND. Required: all outputs 0 the next cycle, then start_ok 1. A new segment is output correctly afterwards.

Source files
------------

// File: rtl/tcp_checksum_inserter.sv
// tcp_checksum_inserter
//
// Store-and-forward stage behind the TCP segment encoder. A whole segment is
// buffered, because the checksum is only known once the encoder has emitted
// the last payload word. When the encoder raises its end-of-segment level,
// the checksum is patched into the header's checksum field and the segment
// is replayed on a valid/ready stream.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   in_data        32-bit encoder word, written when in_wr_en is high
//   in_wr_en       in_data valid this cycle
//   in_fin         end-of-segment level from the encoder
//   in_checksum    final checksum, valid while in_fin is high
//   in_len         segment length in bytes, valid while in_fin is high
//   start_ok       buffer empty and collecting; upstream may start a segment
//   out_data       big-endian segment word (byte 0 in [31:24])
//   out_valid      out_data valid
//   out_ready      downstream accepts the word
//   out_last       final word of the segment
//   out_keep       byte enables, [3] = byte 0
//   out_len        latched segment length in bytes
//   overflow       one-cycle pulse: segment discarded, too many words
//   len_mismatch   sticky: word count disagrees with the byte length

module tcp_checksum_inserter #(
    parameter int ADDR_W = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_wr_en,
    input  logic        in_fin,
    input  logic [15:0] in_checksum,
    input  logic [15:0] in_len,
    output logic        start_ok,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [3:0]  out_keep,
    output logic [15:0] out_len,
    output logic        overflow,
    output logic        len_mismatch
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] IDX4 = (ADDR_W + 1)'(4);

    typedef enum logic {
        COLLECT,
        SEND
    } state_t;

    state_t state;

    logic [31:0]     mem [DEPTH];
    logic [ADDR_W:0] wr_cnt;
    logic [ADDR_W:0] n_q;
    logic [ADDR_W:0] rd_ptr;
    logic            ovf;
    logic            fin_q;
    logic [15:0]     word4_lo;
    logic [15:0]     csum_q;

    // Read stage between the synchronous memory and the output register.
    logic [31:0]     rd_data;
    logic            rd_valid;
    logic            rd_is4;
    logic            rd_last;

    logic            fin_edge;
    logic            wr_full;
    logic            wr_ok;
    logic            ovf_now;
    logic [ADDR_W:0] n_now;
    logic [16:0]     n_ext;
    logic [16:0]     exp_words;
    logic            advance;
    logic            rd_issue;

    // wr_cnt saturates at DEPTH, so its top bit alone means "buffer full".
    assign fin_edge  = in_fin && !fin_q;
    assign wr_full   = wr_cnt[ADDR_W];
    assign wr_ok     = (state == COLLECT) && in_wr_en && !wr_full;
    assign ovf_now   = ovf || ((state == COLLECT) && in_wr_en && wr_full);
    assign n_now     = wr_cnt + (wr_ok ? ONE : '0);
    assign n_ext     = 17'(n_now);
    assign exp_words = {3'b000, in_len[15:2]} + {16'd0, |in_len[1:0]};

    // The output register can take a new word when empty or being consumed;
    // a memory read is issued whenever the read stage will be free for it.
    assign advance  = !out_valid || out_ready;
    assign rd_issue = (state == SEND) && (rd_ptr != n_q) && (!rd_valid || advance);

    assign start_ok = (state == COLLECT) && (wr_cnt == '0) && !ovf;

    function automatic logic [3:0] last_keep(input logic [1:0] len_lsb);
        case (len_lsb)
            2'd0:    last_keep = 4'b1111;
            2'd1:    last_keep = 4'b1000;
            2'd2:    last_keep = 4'b1100;
            default: last_keep = 4'b1110;
        endcase
    endfunction

    // Plain RAM without reset so it can map onto block memory.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_cnt[ADDR_W-1:0]] <= in_data;
        end
        if (rd_issue) begin
            rd_data <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= COLLECT;
            wr_cnt       <= '0;
            n_q          <= '0;
            rd_ptr       <= '0;
            ovf          <= 1'b0;
            fin_q        <= 1'b0;
            word4_lo     <= '0;
            csum_q       <= '0;
            rd_valid     <= 1'b0;
            rd_is4       <= 1'b0;
            rd_last      <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_keep     <= '0;
            out_len      <= '0;
            overflow     <= 1'b0;
            len_mismatch <= 1'b0;
        end else begin
            fin_q    <= in_fin;
            overflow <= 1'b0;

            case (state)
                COLLECT: begin
                    if (in_wr_en) begin
                        if (wr_full) begin
                            ovf <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + ONE;
                            if (wr_cnt == IDX4) begin
                                word4_lo <= in_data[15:0];
                            end
                            if (wr_cnt == '0) begin
                                len_mismatch <= 1'b0;
                            end
                        end
                    end

                    // The fin edge sees the count including a same-cycle write,
                    // so these assignments deliberately override the ones above.
                    if (fin_edge) begin
                        csum_q  <= in_checksum;
                        out_len <= in_len;
                        n_q     <= n_now;
                        if (ovf_now) begin
                            overflow <= 1'b1;
                            wr_cnt   <= '0;
                            ovf      <= 1'b0;
                        end else if (n_now != '0) begin
                            len_mismatch <= (n_ext != exp_words);
                            rd_ptr       <= '0;
                            state        <= SEND;
                        end
                    end
                end

                SEND: begin
                    if (rd_issue) begin
                        rd_ptr  <= rd_ptr + ONE;
                        rd_is4  <= (rd_ptr == IDX4);
                        rd_last <= (rd_ptr == n_q - ONE);
                    end
                    rd_valid <= rd_issue || (rd_valid && !advance);

                    // Output register only moves when it can hand over, which
                    // keeps data/last/keep frozen during backpressure.
                    if (advance) begin
                        out_valid <= rd_valid;
                        if (rd_valid) begin
                            out_data <= rd_is4 ? {csum_q, word4_lo} : rd_data;
                            out_last <= rd_last;
                            out_keep <= rd_last ? last_keep(out_len[1:0]) : 4'b1111;
                        end else begin
                            out_data <= '0;
                            out_last <= 1'b0;
                            out_keep <= '0;
                        end
                    end

                    if (out_valid && out_ready && out_last) begin
                        wr_cnt <= '0;
                        state  <= COLLECT;
                    end
                end

                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_tcp_checksum_inserter.sv
// tb_tcp_checksum_inserter
//
// Directed bench for tcp_checksum_inserter with a small buffer (ADDR_W = 3,
// eight words) so the overflow case stays short. Each segment's expected
// output is derived from the segment contents, checksum and byte length and
// queued; one monitor process checks every handshake against that queue and
// checks that stalled outputs hold.

module tb_tcp_checksum_inserter;

    localparam int ADDR_W = 3;

    logic        clk;
    logic        reset;
    logic [31:0] in_data;
    logic        in_wr_en;
    logic        in_fin;
    logic [15:0] in_checksum;
    logic [15:0] in_len;
    logic        start_ok;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [3:0]  out_keep;
    logic [15:0] out_len;
    logic        overflow;
    logic        len_mismatch;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [3:0]  keep;
        logic [15:0] len;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] seg_words[16];
    int          test_count = 0;
    int          fail_count = 0;
    int          ready_mode = 0;

    tcp_checksum_inserter #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_wr_en     (in_wr_en),
        .in_fin       (in_fin),
        .in_checksum  (in_checksum),
        .in_len       (in_len),
        .start_ok     (start_ok),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .out_keep     (out_keep),
        .out_len      (out_len),
        .overflow     (overflow),
        .len_mismatch (len_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Expected stream: words in order, word 4 carries the checksum in its
    // upper half, last word flagged, and the last word keeps only the bytes
    // the byte length says are real.
    task automatic buildModel(input int n, input logic [15:0] csum, input logic [15:0] len);
        int   tail_bytes;
        exp_t e;
        tail_bytes = (len % 4 == 0) ? 4 : int'(len % 4);
        for (int i = 0; i < n; i++) begin
            e.data = seg_words[i];
            if (i == 4) e.data = {csum, seg_words[4][15:0]};
            e.last = (i == n - 1);
            e.keep = e.last ? 4'(4'hF << (4 - tail_bytes)) : 4'hF;
            e.len  = len;
            exp_q.push_back(e);
        end
    endtask

    // Downstream ready: always high, or the 1,0,0,1 stall pattern.
    initial begin
        int k = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) begin
                out_ready = (k % 4 == 0) || (k % 4 == 3);
                k++;
            end else begin
                out_ready = 1'b1;
                k = 0;
            end
        end
    end

    // Monitor: every handshake must match the next expected word, and a
    // stalled word must still be presented unchanged one cycle later.
    initial begin
        logic        stall_pending = 1'b0;
        logic [31:0] held_data = '0;
        logic        held_last = 1'b0;
        logic [3:0]  held_keep = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (stall_pending) begin
                checkOutput("hold_valid", 32'(out_valid), 32'd1);
                checkOutput("hold_data", out_data, held_data);
                checkOutput("hold_last", 32'(out_last), 32'(held_last));
                checkOutput("hold_keep", 32'(out_keep), 32'(held_keep));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("word_data", out_data, e.data);
                    checkOutput("word_last", 32'(out_last), 32'(e.last));
                    checkOutput("word_keep", 32'(out_keep), 32'(e.keep));
                    checkOutput("word_len", 32'(out_len), 32'(e.len));
                end
            end
            stall_pending = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            held_keep = out_keep;
        end
    end

    // Writes n words from seg_words, raising in_fin with the last write, and
    // checks the cycles right after the fin edge. in_fin is left high.
    task automatic loadSegment(input int n, input logic [15:0] csum, input logic [15:0] len, input bit expect_send);
        int wait_cyc = 0;
        in_fin = 1'b0;
        @(posedge clk);
        #1;
        while (!start_ok && wait_cyc < 200) begin
            @(posedge clk);
            #1;
            wait_cyc++;
        end
        checkOutput("start_ok_before_load", 32'(start_ok), 32'd1);
        for (int i = 0; i < n; i++) begin
            in_wr_en = 1'b1;
            in_data  = seg_words[i];
            if (i == n - 1) begin
                in_fin      = 1'b1;
                in_checksum = csum;
                in_len      = len;
            end
            @(posedge clk);
            #1;
        end
        in_wr_en = 1'b0;
        in_data  = '0;
        if (expect_send) begin
            checkOutput("start_ok_in_send", 32'(start_ok), 32'd0);
            checkOutput("valid_after_fin", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
            checkOutput("valid_fin_plus1", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
            checkOutput("valid_fin_plus2", 32'(out_valid), 32'd1);
            checkOutput("first_word", out_data, exp_q[0].data);
        end else begin
            checkOutput("overflow_pulse", 32'(overflow), 32'd1);
            @(posedge clk);
            #1;
            checkOutput("overflow_cleared", 32'(overflow), 32'd0);
        end
    endtask

    task automatic applyStimulus(input int n, input logic [15:0] csum, input logic [15:0] len,
                                 input bit expect_send, input bit exp_mismatch);
        int cyc = 0;
        loadSegment(n, csum, len, expect_send);
        if (expect_send) begin
            while (exp_q.size() != 0 && cyc < 300) begin
                checkOutput("start_ok_low_while_sending", 32'(start_ok), 32'd0);
                @(posedge clk);
                #1;
                cyc++;
            end
            checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
            checkOutput("valid_after_last", 32'(out_valid), 32'd0);
            checkOutput("start_ok_after_last", 32'(start_ok), 32'd1);
            checkOutput("len_mismatch", 32'(len_mismatch), 32'(exp_mismatch));
        end else begin
            repeat (6) begin
                checkOutput("no_valid_after_overflow", 32'(out_valid), 32'd0);
                @(posedge clk);
                #1;
            end
            checkOutput("start_ok_after_overflow", 32'(start_ok), 32'd1);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_out_data"}, out_data, 32'd0);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_out_last"}, 32'(out_last), 32'd0);
        checkOutput({tag, "_out_keep"}, 32'(out_keep), 32'd0);
        checkOutput({tag, "_out_len"}, 32'(out_len), 32'd0);
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
        checkOutput({tag, "_len_mismatch"}, 32'(len_mismatch), 32'd0);
        checkOutput({tag, "_start_ok"}, 32'(start_ok), 32'd1);
    endtask

    initial begin
        int cyc;
        reset       = 1'b1;
        in_data     = '0;
        in_wr_en    = 1'b0;
        in_fin      = 1'b0;
        in_checksum = '0;
        in_len      = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkResetOutputs("reset");
        reset = 1'b0;

        // Header-only segment, checksum lands in word 4.
        seg_words[0] = 32'h1234ABCD;
        seg_words[1] = 32'h00000001;
        seg_words[2] = 32'h00000002;
        seg_words[3] = 32'h50120400;
        seg_words[4] = 32'h00000007;
        buildModel(5, 16'hBEEF, 16'd20);
        checkOutput("pin_word4", exp_q[4].data, 32'hBEEF0007);
        checkOutput("pin_keep_full", 32'(exp_q[4].keep), 32'h0000000F);
        applyStimulus(5, 16'hBEEF, 16'd20, 1'b1, 1'b0);

        // 22-byte segment: six words, two real bytes in the last one.
        for (int i = 0; i < 6; i++) seg_words[i] = 32'hA0A00000 + 32'(i * 16'h1111);
        buildModel(6, 16'h5A5A, 16'd22);
        checkOutput("pin_keep_22", 32'(exp_q[5].keep), 32'b1100);
        checkOutput("pin_patch_22", exp_q[4].data, 32'h5A5A4444);
        applyStimulus(6, 16'h5A5A, 16'd22, 1'b1, 1'b0);

        // Seven words under the 1,0,0,1 ready pattern, 27 bytes.
        for (int i = 0; i < 7; i++) seg_words[i] = 32'hC0DE0000 + 32'(i);
        buildModel(7, 16'h1357, 16'd27);
        checkOutput("pin_keep_27", 32'(exp_q[6].keep), 32'b1110);
        ready_mode = 1;
        applyStimulus(7, 16'h1357, 16'd27, 1'b1, 1'b0);
        ready_mode = 0;

        // Ten words into an eight-word buffer: discarded, nothing sent.
        for (int i = 0; i < 10; i++) seg_words[i] = 32'hDEAD0000 + 32'(i);
        applyStimulus(10, 16'hFFFF, 16'd40, 1'b0, 1'b0);

        // Normal five-word segment right after the overflow, 17 bytes.
        for (int i = 0; i < 5; i++) seg_words[i] = 32'h0BAD0000 + 32'(i << 8);
        buildModel(5, 16'h2468, 16'd17);
        checkOutput("pin_keep_17", 32'(exp_q[4].keep), 32'b1000);
        applyStimulus(5, 16'h2468, 16'd17, 1'b1, 1'b0);

        // Six words but only 20 bytes claimed: still all sent, flag raised.
        for (int i = 0; i < 6; i++) seg_words[i] = 32'h77770000 + 32'(i);
        buildModel(6, 16'h0F0F, 16'd20);
        applyStimulus(6, 16'h0F0F, 16'd20, 1'b1, 1'b1);

        // in_fin stays high: the level must not start another transmission.
        repeat (20) @(posedge clk);
        #1;
        checkOutput("fin_level_no_resend", 32'(out_valid), 32'd0);
        checkOutput("fin_level_start_ok", 32'(start_ok), 32'd1);
        checkOutput("fin_level_mismatch_sticky", 32'(len_mismatch), 32'd1);

        // Reset while the third word of a segment is on the output.
        for (int i = 0; i < 7; i++) seg_words[i] = 32'h31410000 + 32'(i);
        buildModel(7, 16'h9999, 16'd25);
        loadSegment(7, 16'h9999, 16'd25, 1'b1);
        cyc = 0;
        while (exp_q.size() > 5 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("reached_third_word", out_data, 32'h31410002);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        reset = 1'b0;
        checkResetOutputs("midsend_reset");

        // Fresh segment after the reset, 24 bytes.
        for (int i = 0; i < 6; i++) seg_words[i] = 32'hFACE0000 + 32'(i * 3);
        buildModel(6, 16'hCAFE, 16'd24);
        applyStimulus(6, 16'hCAFE, 16'd24, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
